mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 bit-select mux among four requesters. It owns the mux select `s` and grants one requester at a time. It registers the selected data bit as `y`/`y_vld`. It sits directly in front of the mux and replaces the free-running select with fair, hold-bounded arbitration.

Parameters:
MAX_HOLD, 8, cycles a grant may be held while at least one other requester waits; legal range 1..15.
HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
req  input  4  request per requester; bit i = requester i
a  input  4  data bit per requester; a[i] belongs to requester i
gnt  output  4  one-hot grant, registered; all zero when idle
s  output  2  mux select, registered; index of current or last owner
y  output  1  registered copy of a[s]
y_vld  output  1  y carries data sampled during a grant cycle
busy  output  1  high while in GRANT

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset, at the clock edge with rst_n=0, regardless of state:
  - state=IDLE, gnt=4'b0000, s=2'b00, y=0, y_vld=0, busy=0.
  - ptr=0 (highest priority at requester 0), hold_cnt=0.
- Winner selection (rr_pick): the first set bit of the candidate vector, scanning ptr, ptr+1, ... modulo 4 (wrap 3->0).
- IDLE:
  - If req≠0 at edge k, then at edge k+1: gnt=onehot(winner), s=winner, state=GRANT, hold_cnt=0.
  - Latency from req to gnt is 1 cycle. With req=0, stay in IDLE.
- GRANT, each cycle:
  - y<=a[s] and y_vld<=1, so y lags the select by 1 cycle.
  - hold_cnt increments and saturates at MAX_HOLD.
- Release (owner's req bit = 0):
  - ptr<=s+1 mod 4.
  - If other req bits are set, hand over directly to rr_pick(req excluding the owner, base s+1) at the next edge. There is no idle bubble; hold_cnt=0.
  - Otherwise go to IDLE: gnt=0, busy=0.
- Preempt (owner's req still 1, hold_cnt==MAX_HOLD-1, and another req bit set):
  - Same hand-over as release; the owner goes to the back of the rotation.
- Sole requester: no preemption; the grant is held indefinitely.
- Owner drop and preempt in the same cycle are treated as release (identical result).
- A requester that re-asserts req immediately after its release has the lowest priority on the next pick.
- IDLE outputs:
  - s holds its last value, so the mux select does not toggle.
  - y holds its last value; y_vld=0 from the first IDLE cycle after the final GRANT cycle's sample.
- gnt is always one-hot or zero. s always equals the index of the set gnt bit when busy=1.
- Reset asserted mid-grant: all outputs take reset values at that edge; no partial hand-over.

Decomposition:
- Shared package/header holds:
  - N_REQ=4, SEL_W=2.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - The onehot-from-index and index-from-onehot helper functions.
- One natural sub-module: rr_pick. It is purely combinational, taking a 4-bit candidate vector and a 2-bit base, and returning a 2-bit index plus a found flag. The top level is the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, s=0, y_vld=0, busy=0 throughout.
- req=4'b0100 at cycle 1, a=4'b0100 -> gnt=4'b0100 and s=2 at cycle 2, y=1 with y_vld=1 at cycle 3. Drop req at cycle 6 -> gnt=0 at cycle 7, y_vld=0 at cycle 8, s stays 2.
- req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0. Each owner holds exactly 8 cycles and there are no zero-gnt cycles between owners.
- Owner 3 releases while req=4'b0011 -> next gnt=4'b0001 (wrap 3->0), no bubble. Then owner 0 releases -> gnt=4'b0010.
- Sole requester 1 held for 40 cycles -> gnt=4'b0010 for all 40 cycles. Assert req[2] at cycle 41 -> preempt to requester 2 at most MAX_HOLD cycles later.
- rst_n=0 for one cycle while owner 2 is mid-grant -> next cycle gnt=0, s=0, y=0, y_vld=0. After release with req=4'b1111, first gnt=4'b0001.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: sizes, FSM state
// encoding and the index <-> one-hot conversion helpers.
package mux_rr_arbiter_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // One-hot vector with only bit idx set.
   function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Index of the set bit of a one-hot vector (highest set bit wins if
   // more than one is set; zero for an all-zero vector).
   function automatic logic [SEL_W-1:0] idx_from_onehot(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = i[SEL_W-1:0];
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set candidate bit
// found when scanning base, base+1, ... with wrap-around.
module mux_rr_arbiter_rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] i_cand,
   input  logic [SEL_W-1:0] i_base,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_found
);

   // Candidates rotated so that position 0 is the base requester.
   logic [N_REQ-1:0] w_rot;
   // Lowest set bit of the rotated vector, isolated as one-hot.
   logic [N_REQ-1:0] w_first;
   logic [SEL_W-1:0] w_offset;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         logic [SEL_W-1:0] w_pos;
         // Modulo-4 wrap comes for free from the 2-bit adder.
         assign w_pos     = i_base + SEL_W'(gi);
         assign w_rot[gi] = i_cand[w_pos];
      end
   endgenerate

   // Two's-complement trick keeps only the lowest set bit.
   assign w_first  = w_rot & (~w_rot + N_REQ'(1));
   assign w_offset = idx_from_onehot(w_first);

   assign o_idx   = i_base + w_offset;
   assign o_found = |i_cand;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 bit-select mux. Grants one requester
// at a time, bounds how long a grant is held while others wait, and
// registers the selected data bit.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,   // legal range 1..15
   parameter int HOLD_W   = 4    // 2**HOLD_W must exceed MAX_HOLD
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] a,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] s,
   output logic             y,
   output logic             y_vld,
   output logic             busy
);

   state_t            r_state;
   logic [N_REQ-1:0]  r_gnt;
   logic [SEL_W-1:0]  r_s;
   logic              r_y;
   logic              r_y_vld;
   logic [SEL_W-1:0]  r_ptr;
   logic [HOLD_W-1:0] r_hold_cnt;

   logic [N_REQ-1:0]  w_owner_oh;
   logic              w_owner_req;
   logic [N_REQ-1:0]  w_others;
   logic              w_hold_limit;
   logic              w_release;
   logic              w_preempt;
   logic              w_handover;
   logic [SEL_W-1:0]  w_next_base;
   logic [N_REQ-1:0]  w_pick_cand;
   logic [SEL_W-1:0]  w_pick_base;
   logic [SEL_W-1:0]  w_pick_idx;
   logic              w_pick_found;

   assign w_owner_oh  = onehot_from_idx(r_s);
   assign w_owner_req = |(req & w_owner_oh);
   assign w_others    = req & ~w_owner_oh;
   assign w_next_base = r_s + SEL_W'(1);

   // The counter saturates at MAX_HOLD, so ">=" rather than "==" is used:
   // an owner that has been alone for a long time is preempted on the very
   // next cycle a competitor shows up instead of never.
   assign w_hold_limit = (r_hold_cnt >= HOLD_W'(MAX_HOLD - 1));
   assign w_release    = ~w_owner_req;
   assign w_preempt    = w_owner_req & w_hold_limit & (|w_others);
   assign w_handover   = w_release | w_preempt;

   // One picker serves both cases: a fresh pick from IDLE starting at ptr,
   // and a hand-over that excludes the owner and starts just past it.
   assign w_pick_cand = (r_state == ST_IDLE) ? req   : w_others;
   assign w_pick_base = (r_state == ST_IDLE) ? r_ptr : w_next_base;

   mux_rr_arbiter_rr_pick u_pick (
      .i_cand  (w_pick_cand),
      .i_base  (w_pick_base),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   // Arbitration FSM with pointer, hold counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_s        <= '0;
         r_y        <= 1'b0;
         r_y_vld    <= 1'b0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // s and y hold so the mux select does not toggle while idle.
               r_y_vld <= 1'b0;
               if (w_pick_found) begin
                  r_state    <= ST_GRANT;
                  r_gnt      <= onehot_from_idx(w_pick_idx);
                  r_s        <= w_pick_idx;
                  r_hold_cnt <= '0;
               end
            end
            ST_GRANT: begin
               r_y     <= a[r_s];
               r_y_vld <= 1'b1;
               if (w_handover) begin
                  // Releasing or preempted owner moves to the back.
                  r_ptr <= w_next_base;
                  if (w_pick_found) begin
                     r_gnt      <= onehot_from_idx(w_pick_idx);
                     r_s        <= w_pick_idx;
                     r_hold_cnt <= '0;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_gnt      <= '0;
                     r_hold_cnt <= '0;
                  end
               end else if (r_hold_cnt < HOLD_W'(MAX_HOLD)) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign s     = r_s;
   assign y     = r_y;
   assign y_vld = r_y_vld;
   assign busy  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table for single-cycle
// behaviour plus sequences for rotation, long sole ownership and preemption.
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] a;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       y;
   logic       y_vld;
   logic       busy;

   int total;
   int bad;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] a;
      logic [3:0] gnt;
      logic [1:0] s;
      logic       y;
      logic       vld;
      logic       busy;
   } vec_t;

   vec_t vq[$];

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .a     (a),
      .gnt   (gnt),
      .s     (s),
      .y     (y),
      .y_vld (y_vld),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One comparison of the full output bundle {gnt,s,y,y_vld,busy}.
   task automatic check(input string name, input logic [8:0] exp);
      logic [8:0] act;
      act = {gnt, s, y, y_vld, busy};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got gnt=%b s=%0d y=%b vld=%b busy=%b want gnt=%b s=%0d y=%b vld=%b busy=%b",
                  name, act[8:5], act[4:3], act[2], act[1], act[0],
                  exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
      end else begin
         $display("ok   %s gnt=%b s=%0d y=%b vld=%b busy=%b",
                  name, act[8:5], act[4:3], act[2], act[1], act[0]);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] av,
                      input logic [3:0] g, input logic [1:0] sv, input logic yv,
                      input logic vv, input logic bv);
      vq.push_back('{r, rq, av, g, sv, yv, vv, bv});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      a     = 4'b0000;

      //    rst  req      a        gnt      s  y  vld busy
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);  // reset
      for (int i = 0; i < 5; i++)
         add(1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);  // idle
      add(1'b1, 4'b0100, 4'b0100, 4'b0100, 2, 0, 0, 1);  // grant 2
      add(1'b1, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 1);  // y=a[2]
      add(1'b1, 4'b0100, 4'b0000, 4'b0100, 2, 0, 1, 1);
      add(1'b1, 4'b0000, 4'b0100, 4'b0000, 2, 1, 1, 0);  // release -> idle
      add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2, 1, 0, 0);  // s, y hold
      add(1'b1, 4'b0011, 4'b0001, 4'b0001, 0, 1, 0, 1);  // ptr=3 wraps to 0
      add(1'b1, 4'b0011, 4'b0001, 4'b0001, 0, 1, 1, 1);
      add(1'b1, 4'b0010, 4'b0000, 4'b0010, 1, 0, 1, 1);  // hand-over, no bubble
      add(1'b1, 4'b1010, 4'b0010, 4'b0010, 1, 1, 1, 1);
      add(1'b1, 4'b1000, 4'b0000, 4'b1000, 3, 0, 1, 1);
      add(1'b1, 4'b1011, 4'b1000, 4'b1000, 3, 1, 1, 1);
      add(1'b1, 4'b0011, 4'b0000, 4'b0001, 0, 0, 1, 1);  // owner 3 drops -> 0
      add(1'b1, 4'b0010, 4'b0001, 4'b0010, 1, 1, 1, 1);  // owner 0 drops -> 1
      add(1'b1, 4'b0011, 4'b0000, 4'b0010, 1, 0, 1, 1);
      add(1'b0, 4'b0011, 4'b1111, 4'b0000, 0, 0, 0, 0);  // reset mid-grant
      add(1'b1, 4'b0110, 4'b0000, 4'b0010, 1, 0, 0, 1);
      add(1'b1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0);  // release, ptr=2
      add(1'b1, 4'b0011, 4'b0000, 4'b0001, 0, 0, 0, 1);  // 1 now lowest
      add(1'b1, 4'b0100, 4'b0000, 4'b0100, 2, 0, 1, 1);  // owner 2
      add(1'b0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0);  // reset owner 2
      add(1'b1, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, 1);  // restart at 0

      foreach (vq[i]) begin
         rst_n = vq[i].rst_n;
         req   = vq[i].req;
         a     = vq[i].a;
         step();
         check($sformatf("vec%0d", i),
               {vq[i].gnt, vq[i].s, vq[i].y, vq[i].vld, vq[i].busy});
      end

      // Full contention: each owner keeps the grant MAX_HOLD cycles.
      rst_n = 1'b0;
      req   = 4'b0000;
      a     = 4'b0000;
      step();
      rst_n = 1'b1;
      req   = 4'b1111;
      for (int c = 0; c < 5 * MAX_HOLD; c++) begin
         logic [1:0] own;
         logic [3:0] oh;
         own = 2'((c / MAX_HOLD) % 4);
         oh  = 4'b0001 << own;
         step();
         check($sformatf("rot%0d", c), {oh, own, 1'b0, (c > 0), 1'b1});
      end

      // Sole requester holds indefinitely, then is preempted.
      rst_n = 1'b0;
      req   = 4'b0000;
      step();
      rst_n = 1'b1;
      req   = 4'b0010;
      a     = 4'b0010;
      for (int c = 0; c < 40; c++) begin
         step();
         check($sformatf("sole%0d", c), {4'b0010, 2'd1, (c > 0), (c > 0), 1'b1});
      end
      req   = 4'b0110;
      found = 1'b0;
      for (int c = 0; c < MAX_HOLD && !found; c++) begin
         step();
         if (gnt === 4'b0100 && s === 2'd2) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL preempt got gnt=%b s=%0d want gnt=0100 s=2 within %0d cycles",
                  gnt, s, MAX_HOLD);
      end else begin
         $display("ok   preempt gnt=%b s=%0d", gnt, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
